// File: rtl/pipe_stage_buf_pkg.sv
// Shared sizing helpers for the elastic pipeline-stage buffer.
package pipe_stage_buf_pkg;

    // Pointer width for a DEPTH-slot circular array; at least one bit so DEPTH=1 still has a pointer.
    function automatic int unsigned ptr_width(input int unsigned depth);
        int unsigned w;
        w = $clog2(depth);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/pipe_stage_buf.sv
// Elastic DEPTH-entry pipeline-stage register with stall and flush; 1-cycle minimum latency.
// Ready/valid depend only on en, flush, reset and registered occupancy: no combinational ready path.
module pipe_stage_buf
    import pipe_stage_buf_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    input  logic             en,
    input  logic             flush,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty
);

    localparam int PW = ptr_width(DEPTH);

    if (WIDTH < 1 || DEPTH < 1) begin : g_param_check
        $error("pipe_stage_buf: WIDTH and DEPTH must both be at least 1");
    end

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    rp_q, rp_d;
    logic [PW-1:0]    wp_q, wp_d;
    logic [CW-1:0]    count_q, count_d;
    logic             hs_en;
    logic             push;
    logic             pop;

    // Explicit wrap at DEPTH-1 so non-power-of-two depths work.
    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        full      = (count_q == CW'(DEPTH));
        empty     = (count_q == '0);
        hs_en     = ~RST & en & ~flush;
        in_ready  = hs_en & ~full;
        out_valid = hs_en & ~empty;
        push      = in_valid & in_ready;
        pop       = out_valid & out_ready;
        out_data  = mem_q[rp_q];
        count     = count_q;
    end

    always_comb begin
        rp_d    = rp_q;
        wp_d    = wp_q;
        count_d = count_q;
        if (flush) begin
            rp_d    = '0;
            wp_d    = '0;
            count_d = '0;
        end else begin
            if (push) wp_d = next_ptr(wp_q);
            if (pop)  rp_d = next_ptr(rp_q);
            if (push && !pop)      count_d = count_q + CW'(1);
            else if (pop && !push) count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            rp_q    <= '0;
            wp_q    <= '0;
            count_q <= '0;
        end else begin
            rp_q    <= rp_d;
            wp_q    <= wp_d;
            count_q <= count_d;
        end
    end

    // Payload storage needs no reset: out_data is only meaningful while out_valid is high.
    always_ff @(posedge CLK) begin
        if (push) mem_q[wp_q] <= in_data;
    end

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Directed vector bench for pipe_stage_buf at DEPTH=2 (table) and DEPTH=3 (wrap sequence).
module tb_pipe_stage_buf;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    // DEPTH=2 instance
    logic        rst2, iv2, irdy2, ov2, ordy2, en2, fl2, full2, empty2;
    logic [31:0] id2, od2;
    logic [1:0]  cnt2;

    // DEPTH=3 instance
    logic        rst3, iv3, irdy3, ov3, ordy3, en3, fl3, full3, empty3;
    logic [31:0] id3, od3;
    logic [1:0]  cnt3;

    pipe_stage_buf #(.WIDTH(32), .DEPTH(2)) u_d2 (
        .CLK(clk), .RST(rst2), .in_valid(iv2), .in_ready(irdy2), .in_data(id2),
        .out_valid(ov2), .out_ready(ordy2), .out_data(od2), .en(en2), .flush(fl2),
        .count(cnt2), .full(full2), .empty(empty2)
    );

    pipe_stage_buf #(.WIDTH(32), .DEPTH(3)) u_d3 (
        .CLK(clk), .RST(rst3), .in_valid(iv3), .in_ready(irdy3), .in_data(id3),
        .out_valid(ov3), .out_ready(ordy3), .out_data(od3), .en(en3), .flush(fl3),
        .count(cnt3), .full(full3), .empty(empty3)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input int row, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s row %0d: got 0x%0h expected 0x%0h", name, row, act, exp);
        end
    endtask

    typedef struct {
        logic        rst, iv;
        logic [31:0] id;
        logic        ordy, en, fl;
        logic        e_irdy, e_ov;
        logic [31:0] e_od;
        int          e_cnt;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic rst, input logic iv, input logic [31:0] id,
                                input logic ordy, input logic en, input logic fl,
                                input logic e_irdy, input logic e_ov, input logic [31:0] e_od,
                                input int e_cnt);
        vec_t v;
        v.rst = rst; v.iv = iv; v.id = id; v.ordy = ordy; v.en = en; v.fl = fl;
        v.e_irdy = e_irdy; v.e_ov = e_ov; v.e_od = e_od; v.e_cnt = e_cnt;
        return v;
    endfunction

    initial begin
        //              rst iv id      ordy en fl | irdy ov od     cnt
        // reset held with an input offered
        tbl.push_back(mk(1, 1, 32'h55, 0, 1, 0,   0, 0, 0,     0));
        tbl.push_back(mk(1, 1, 32'h55, 0, 1, 0,   0, 0, 0,     0));
        tbl.push_back(mk(0, 0, 0,      0, 1, 0,   1, 0, 0,     0));
        // streaming 1..4, downstream always ready
        tbl.push_back(mk(0, 1, 32'h1,  1, 1, 0,   1, 0, 0,     0));
        tbl.push_back(mk(0, 1, 32'h2,  1, 1, 0,   1, 1, 32'h1, 1));
        tbl.push_back(mk(0, 1, 32'h3,  1, 1, 0,   1, 1, 32'h2, 1));
        tbl.push_back(mk(0, 1, 32'h4,  1, 1, 0,   1, 1, 32'h3, 1));
        tbl.push_back(mk(0, 0, 0,      1, 1, 0,   1, 1, 32'h4, 1));
        tbl.push_back(mk(0, 0, 0,      1, 1, 0,   1, 0, 0,     0));
        // fill and back-pressure
        tbl.push_back(mk(0, 1, 32'hA,  0, 1, 0,   1, 0, 0,     0));
        tbl.push_back(mk(0, 1, 32'hB,  0, 1, 0,   1, 1, 32'hA, 1));
        tbl.push_back(mk(0, 1, 32'hC,  0, 1, 0,   0, 1, 32'hA, 2));
        tbl.push_back(mk(0, 1, 32'hC,  1, 1, 0,   0, 1, 32'hA, 2));
        tbl.push_back(mk(0, 1, 32'hC,  1, 1, 0,   1, 1, 32'hB, 1));
        tbl.push_back(mk(0, 0, 0,      1, 1, 0,   1, 1, 32'hC, 1));
        // stall with two entries stored
        tbl.push_back(mk(0, 1, 32'hA,  0, 1, 0,   1, 0, 0,     0));
        tbl.push_back(mk(0, 1, 32'hB,  0, 1, 0,   1, 1, 32'hA, 1));
        tbl.push_back(mk(0, 1, 32'hD,  1, 0, 0,   0, 0, 0,     2));
        tbl.push_back(mk(0, 1, 32'hD,  1, 0, 0,   0, 0, 0,     2));
        tbl.push_back(mk(0, 1, 32'hD,  1, 0, 0,   0, 0, 0,     2));
        tbl.push_back(mk(0, 0, 0,      1, 1, 0,   0, 1, 32'hA, 2));
        tbl.push_back(mk(0, 0, 0,      1, 1, 0,   1, 1, 32'hB, 1));
        tbl.push_back(mk(0, 0, 0,      1, 1, 0,   1, 0, 0,     0));
        // flush beats stall and squashes the same-cycle input
        tbl.push_back(mk(0, 1, 32'hA,  0, 1, 0,   1, 0, 0,     0));
        tbl.push_back(mk(0, 1, 32'hB,  0, 1, 0,   1, 1, 32'hA, 1));
        tbl.push_back(mk(0, 1, 32'hF,  1, 0, 1,   0, 0, 0,     2));
        tbl.push_back(mk(0, 0, 0,      1, 1, 0,   1, 0, 0,     0));
        tbl.push_back(mk(0, 0, 0,      1, 1, 0,   1, 0, 0,     0));
        // reset mid-operation overrides flush and stall
        tbl.push_back(mk(0, 1, 32'h77, 0, 1, 0,   1, 0, 0,     0));
        tbl.push_back(mk(1, 1, 32'h78, 0, 0, 1,   0, 0, 0,     1));
        tbl.push_back(mk(0, 0, 0,      1, 1, 0,   1, 0, 0,     0));
    end

    initial begin
        int got, i, cyc;
        bit saw_full;

        rst2 = 1; iv2 = 0; id2 = 0; ordy2 = 0; en2 = 1; fl2 = 0;
        rst3 = 1; iv3 = 0; id3 = 0; ordy3 = 0; en3 = 1; fl3 = 0;
        @(posedge clk);
        #1;

        for (int r = 0; r < tbl.size(); r++) begin
            rst2 = tbl[r].rst; iv2 = tbl[r].iv; id2 = tbl[r].id;
            ordy2 = tbl[r].ordy; en2 = tbl[r].en; fl2 = tbl[r].fl;
            @(negedge clk);
            check("in_ready",  r, irdy2, tbl[r].e_irdy);
            check("out_valid", r, ov2,   tbl[r].e_ov);
            check("count",     r, cnt2,  tbl[r].e_cnt);
            check("full",      r, full2, (tbl[r].e_cnt == 2));
            check("empty",     r, empty2, (tbl[r].e_cnt == 0));
            if (tbl[r].e_ov) check("out_data", r, od2, tbl[r].e_od);
            @(posedge clk);
            #1;
        end

        // DEPTH=3: values 0..9, downstream stalled for the first 3 cycles so the
        // buffer fills, then drains while pushing so both pointers cross 2->0.
        rst3 = 0;
        i = 0; got = 0; saw_full = 0;
        for (cyc = 0; cyc < 100 && got < 10; cyc++) begin
            iv3 = (i < 10);
            id3 = i;
            ordy3 = (cyc >= 3);
            @(negedge clk);
            if (cnt3 > 3) check("wrap_count_bound", cyc, cnt3, 3);
            if (cyc == 3) begin
                check("wrap_full_count", cyc, cnt3, 3);
                check("wrap_full_flag", cyc, full3, 1);
                check("wrap_full_irdy", cyc, irdy3, 0);
                saw_full = 1;
            end
            if (ov3 && ordy3) begin
                check("wrap_order", got, od3, got);
                got++;
            end
            if (iv3 && irdy3) i++;
            @(posedge clk);
            #1;
        end
        iv3 = 0; ordy3 = 0;
        check("wrap_received", 0, got, 10);
        check("wrap_full_seen", 0, saw_full, 1);
        @(negedge clk);
        check("wrap_empty_end", 0, empty3, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
